ifu_fetch_ctrl: RTL and testbench
=================================

Name: ifu_fetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the NPC instruction memory.
- Owns the fetch PC, which resets to the boot vector 0x80000000.
- Issues one request at a time to the imem over a valid/ready request channel with variable-latency response, and presents each fetched instruction plus its PC to decode over a valid/ready handshake.
- Handles branch/jump redirects, including discarding stale in-flight responses.

Parameters:
- RESET_PC, 32'h80000000, fetch address after reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  fetch enable; low halts fetch at the next request boundary (ebreak/halt).
- redirect_valid  input  1  one-cycle redirect strobe from execute.
- redirect_pc  input  32  redirect target.
- imem_req_valid  output  1  request valid.
- imem_req_addr  output  32  request address; equals fetch_pc.
- imem_req_ready  input  1  imem accepts the request.
- imem_rsp_valid  input  1  response valid; always accepted, no back-pressure.
- imem_rsp_data  input  32  response instruction word.
- inst_valid  output  1  instruction valid to decode.
- inst_pc  output  32  PC of the presented instruction.
- inst_data  output  32  presented instruction.
- inst_ready  input  1  decode consumes the instruction.

Behaviour:
- Registers:
  - fetch_pc: reset RESET_PC.
  - redir_pend: reset 0.
  - redir_pc: reset 0.
  - inst_data: reset 0.
  - state: reset IDLE.
- Reset values of outputs: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_pc=RESET_PC, inst_data=0.
- Reset asserted mid-transaction returns immediately to IDLE. The bench must not deliver a stale rsp after reset release.
- States: IDLE, REQ, WAIT, HOLD, FLUSH.
- IDLE:
  - Outputs: req_valid=0, inst_valid=0.
  - redirect_valid: fetch_pc<=redirect_pc.
  - fetch_en=1: go to REQ next cycle.
- REQ:
  - Outputs: req_valid=1, imem_req_addr=fetch_pc. The address stays stable until the handshake.
  - redirect_valid without handshake: redir_pend<=1, redir_pc<=redirect_pc; stay in REQ with the address unchanged.
  - Handshake (req_valid & req_ready): go to FLUSH if redir_pend or redirect_valid is set that cycle (capture redirect_pc into redir_pc); otherwise go to WAIT.
- WAIT:
  - The response arrives at the earliest one cycle after the handshake.
  - rsp_valid & !redirect_valid: inst_data<=rsp_data, inst_pc<=fetch_pc; go to HOLD.
  - rsp_valid & redirect_valid: discard the response; fetch_pc<=redirect_pc; go to REQ if fetch_en, else IDLE.
  - redirect_valid only: redir_pc<=redirect_pc, redir_pend<=1; go to FLUSH.
- FLUSH:
  - Waits for the stale response and discards it. A redirect arriving in FLUSH overwrites redir_pc (latest wins).
  - On rsp_valid: fetch_pc<=(redirect_valid ? redirect_pc : redir_pc), redir_pend<=0; go to REQ if fetch_en, else IDLE.
- HOLD:
  - Output: inst_valid=1.
  - redirect_valid has priority over inst_ready. The instruction is dropped (treated as not consumed), fetch_pc<=redirect_pc, and the next state is REQ if fetch_en, else IDLE.
  - Else inst_ready: fetch_pc<=fetch_pc+PC_STEP (32-bit wrap, 0xFFFFFFFC -> 0x00000000); go to REQ if fetch_en, else IDLE.
  - Else: hold, with inst_pc and inst_data stable.
- Invariants:
  - At most one imem request is outstanding.
  - A discarded response is never presented to decode.
  - fetch_en low does not abort an accepted request; the response is still presented.
- Best-case throughput: 1 instruction per 3 cycles (REQ with ready=1, WAIT with 1-cycle rsp, HOLD with ready=1).

Optional Feature:
- Macro: IFU_MISALIGN_CHK_EN.
- Defined:
  - Adds output port fetch_misalign (1 bit, reset 0).
  - A redirect target with [1:0]!=0 issues no imem request. fetch_pc<=target, and the next state is HOLD with inst_pc=target, inst_data=0, fetch_misalign=1.
  - fetch_misalign clears when HOLD exits.
- Undefined: redirect_pc[1:0] is forced to 2'b00 on capture and no port is added.

Test Plan:
- Reset release, fetch_en=1, req_ready=1, 1-cycle rsp 0x00500513, inst_ready=1: req addrs 0x80000000, 0x80000004, 0x80000008; inst_pc matches each; inst_valid once every 3 cycles.
- inst_ready low 5 cycles in HOLD: inst_valid stays 1, inst_pc/inst_data stable, no new req; 1 cycle after ready, req addr = prev+4.
- redirect_pc=0x80000100 while in WAIT, rsp 3 cycles later = 0xDEADBEEF: 0xDEADBEEF is never presented; next req addr = 0x80000100.
- req_ready held low 4 cycles with redirect 0x80000040 in cycle 2: req addr stays 0x80000000 until accept; that response is discarded; next req = 0x80000040.
- Simultaneous redirect 0x80000200 and inst_ready in HOLD: instruction dropped, next req = 0x80000200 (not pc+4).
- With IFU_MISALIGN_CHK_EN, redirect to 0x80000102: no imem req, inst_valid=1, inst_pc=0x80000102, fetch_misalign=1, inst_data=0.

Source files
------------

// File: rtl/ifu_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, keeps one imem request in flight and presents
// fetched words to decode. Define IFU_MISALIGN_CHK_EN to trap misaligned redirect targets.
module ifu_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
`ifdef IFU_MISALIGN_CHK_EN
  output logic        fetch_misalign,
`endif
  input  logic        inst_ready
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StHold, StFlush} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        redir_pend_q, redir_pend_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] inst_data_q, inst_data_d;
  logic [31:0] tgt_pc;
  logic        jump;
  logic [31:0] jump_pc;
  state_e      resume;

`ifdef IFU_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;
  assign tgt_pc = redirect_pc;
`else
  assign tgt_pc = redirect_pc & ~32'h3;
`endif

  assign resume = fetch_en ? StReq : StIdle;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;
    inst_pc_d    = inst_pc_q;
    inst_data_d  = inst_data_q;
    jump         = 1'b0;
    jump_pc      = '0;
`ifdef IFU_MISALIGN_CHK_EN
    misalign_d   = misalign_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (redirect_valid) begin
          jump    = 1'b1;
          jump_pc = tgt_pc;
        end else if (fetch_en) begin
          state_d = StReq;
        end
      end
      StReq: begin
        // The address is held until accepted; a redirect here only marks the request stale.
        if (imem_req_ready) begin
          if (redirect_valid) begin
            redir_pc_d   = tgt_pc;
            redir_pend_d = 1'b1;
          end
          state_d = (redir_pend_q || redirect_valid) ? StFlush : StWait;
        end else if (redirect_valid) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = tgt_pc;
        end
      end
      StWait: begin
        if (imem_rsp_valid) begin
          if (redirect_valid) begin
            jump    = 1'b1;
            jump_pc = tgt_pc;
          end else begin
            inst_data_d = imem_rsp_data;
            inst_pc_d   = fetch_pc_q;
            state_d     = StHold;
          end
        end else if (redirect_valid) begin
          redir_pc_d   = tgt_pc;
          redir_pend_d = 1'b1;
          state_d      = StFlush;
        end
      end
      StFlush: begin
        if (redirect_valid) redir_pc_d = tgt_pc;
        if (imem_rsp_valid) begin
          redir_pend_d = 1'b0;
          jump         = 1'b1;
          jump_pc      = redirect_valid ? tgt_pc : redir_pc_q;
        end
      end
      StHold: begin
        if (redirect_valid) begin
          jump    = 1'b1;
          jump_pc = tgt_pc;
        end else if (inst_ready) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          state_d    = resume;
        end
      end
      default: state_d = StIdle;
    endcase

    if (jump) begin
      fetch_pc_d = jump_pc;
      state_d    = resume;
    end

`ifdef IFU_MISALIGN_CHK_EN
    if (state_q == StHold && state_d != StHold) misalign_d = 1'b0;
    // A misaligned target is reported to decode instead of being fetched.
    if (jump && jump_pc[1:0] != 2'b00) begin
      state_d     = StHold;
      inst_pc_d   = jump_pc;
      inst_data_d = '0;
      misalign_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
      inst_pc_q    <= RESET_PC;
      inst_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      inst_pc_q    <= inst_pc_d;
      inst_data_q  <= inst_data_d;
    end
  end

`ifdef IFU_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= misalign_d;
  end
  assign fetch_misalign = misalign_q;
`endif

  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = (state_q == StHold);
  assign inst_pc        = inst_pc_q;
  assign inst_data      = inst_data_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Randomised scoreboard bench for ifu_fetch_ctrl: the driver acts as imem and decode, a
// transaction-level model predicts request addresses and presented instructions.
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RstPc = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready = 1'b0;

  always #5 clk = ~clk;

  ifu_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .inst_ready     (inst_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected request addresses and expected {pc, data} presentations, in order.
  logic [31:0] req_q[$];
  logic [63:0] inst_q[$];

  int p_rdy, p_irdy, p_en, p_redir, max_lat;
  logic        force_valid = 1'b0;
  logic [31:0] force_pc = '0;

  // Transaction-level model: next architectural fetch address plus the open request.
  logic [31:0] model_pc;
  logic [31:0] req_pc;
  bit          busy, taint, outst;
  int          lat;
  int          iv_count;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    model_pc = RstPc;
    busy     = 1'b0;
    taint    = 1'b0;
    outst    = 1'b0;
    lat      = 0;
    req_q.delete();
    inst_q.delete();
  endtask

  task automatic check_reset();
    check32("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check32("rst_req_addr", imem_req_addr, RstPc);
    check32("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check32("rst_inst_pc", inst_pc, RstPc);
    check32("rst_inst_data", inst_data, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    inst_ready     = 1'b0;
    model_reset();
    #1;
    check_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_pc();
    int unsigned s;
    s = $urandom_range(9);
    if (s == 0) return 32'hFFFF_FFFC;
    if (s == 1) return $urandom;
    return RstPc | ($urandom & 32'h0000_0FFF);
  endfunction

  // One clock: sample DUT state, drive this cycle's inputs, advance the model.
  task automatic cycle();
    logic rv, iv, hs;
    @(negedge clk);
    rv = imem_req_valid;
    iv = inst_valid;
    if (iv) iv_count++;

    redirect_valid = 1'b0;
    if (force_valid) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_valid    = 1'b0;
    end else if (int'($urandom_range(99)) < p_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = rand_pc();
    end
    fetch_en       = int'($urandom_range(99)) < p_en;
    imem_req_ready = int'($urandom_range(99)) < p_rdy;
    inst_ready     = int'($urandom_range(99)) < p_irdy;
    imem_rsp_valid = 1'b0;
    if (outst) begin
      if (lat == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = $urandom;
        outst          = 1'b0;
      end else begin
        lat--;
      end
    end

    hs = rv & imem_req_ready;
    if (rv && !busy) begin
      busy   = 1'b1;
      taint  = 1'b0;
      req_pc = model_pc;
      req_q.push_back(model_pc);
    end
    if (hs) begin
      n_checks++;
      if (outst || imem_rsp_valid) begin
        n_errors++;
        $display("FAIL one_outstanding: got 2 requests in flight, expected at most 1");
      end
      outst = 1'b1;
      lat   = $urandom_range(max_lat);
    end

    if (redirect_valid) begin
      model_pc = redirect_pc & ~32'h3;
      if (busy) taint = 1'b1;
    end else if (iv && inst_ready) begin
      model_pc = model_pc + 32'd4;
    end

    if (imem_rsp_valid) begin
      if (!taint && !redirect_valid) inst_q.push_back({req_pc, imem_rsp_data});
      busy = 1'b0;
    end
  endtask

  task automatic run(input int rdy, input int irdy, input int en, input int redir,
                     input int lmax, input int n);
    p_rdy   = rdy;
    p_irdy  = irdy;
    p_en    = en;
    p_redir = redir;
    max_lat = lmax;
    repeat (n) cycle();
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard queues.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (imem_req_valid) begin
          if (req_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL req_unexpected: got request to %08h, expected none", imem_req_addr);
          end else begin
            check32("req_addr", imem_req_addr, req_q[0]);
            if (imem_req_ready) void'(req_q.pop_front());
          end
        end
        if (inst_valid) begin
          if (inst_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL inst_unexpected: got pc %08h data %08h, expected none",
                     inst_pc, inst_data);
          end else begin
            e = inst_q[0];
            check32("inst_pc", inst_pc, e[63:32]);
            check32("inst_data", inst_data, e[31:0]);
            if (inst_ready || redirect_valid) void'(inst_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with no stalls: IDLE, then one instruction every third cycle.
    iv_count = 0;
    run(100, 100, 100, 0, 0, 31);
    check32("throughput", iv_count, 32'd10);

    // Address wrap at the top of the space.
    force_valid = 1'b1;
    force_pc    = 32'hFFFF_FFFC;
    run(100, 100, 100, 0, 0, 12);

    // Decode stall, imem stall and slow responses.
    run(100, 0, 100, 0, 0, 8);
    run(0, 100, 100, 0, 0, 6);
    run(100, 100, 100, 0, 3, 20);

    run(60, 70, 90, 10, 3, 800);
    run(30, 40, 80, 25, 4, 800);
    run(90, 90, 100, 5, 0, 800);
    run(50, 50, 50, 40, 2, 800);

    apply_reset();
    run(70, 70, 90, 15, 3, 600);

    // Drain: no new fetches, everything outstanding must complete.
    run(100, 100, 0, 0, 0, 30);
    check32("drain_req_q", req_q.size(), 32'd0);
    check32("drain_inst_q", inst_q.size(), 32'd0);
    check32("drain_outstanding", {31'd0, outst}, 32'd0);
    check32("drain_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check32("drain_inst_valid", {31'd0, inst_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
